// File: rtl/ahbl_protocol_monitor.sv
// rtl/ahbl_protocol_monitor.sv - passive AHB-Lite protocol checker with sticky violation flags and counters
module ahbl_protocol_monitor #(
    parameter int W_ADDR   = 32,
    parameter int W_DATA   = 32,
    parameter int MAX_WAIT = 16,
    parameter int W_CNT    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hready,
    input  logic              hresp,
    input  logic [W_ADDR-1:0] haddr,
    input  logic              hwrite,
    input  logic [1:0]        htrans,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [3:0]        hprot,
    input  logic              hmastlock,
    input  logic [W_DATA-1:0] hwdata,
    input  logic              clr,
    output logic [7:0]        err_flags,
    output logic              err_valid,
    output logic [2:0]        err_first,
    output logic [W_CNT-1:0]  err_count,
    output logic [W_CNT-1:0]  xfer_count
);

    localparam logic [1:0] TR_IDLE = 2'b00;
    localparam logic [1:0] TR_BUSY = 2'b01;
    localparam logic [1:0] TR_NSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ  = 2'b11;

    localparam logic [W_ADDR-1:0] A_ONE     = {{(W_ADDR-1){1'b0}}, 1'b1};
    localparam logic [W_CNT-1:0]  CNT_ONE   = {{(W_CNT-1){1'b0}}, 1'b1};
    localparam logic [7:0]        WAIT_MAX  = 8'(MAX_WAIT);
    localparam logic [7:0]        WAIT_LAST = 8'(MAX_WAIT - 1);

    typedef enum logic {B_IDLE, B_BURST} burst_state_t;
    typedef enum logic {R_OK, R_ERR1} resp_state_t;

    burst_state_t b_state, b_state_n;
    resp_state_t  r_state, r_state_n;

    // burst tracking
    logic [3:0]        b_remain, b_remain_n;
    logic              b_fixed, b_fixed_n;
    logic [W_ADDR-1:0] b_exp, b_exp_n;
    logic [W_ADDR-1:0] b_mask, b_mask_n;
    logic              b_last, b_last_n;

    // data phase and previous-cycle snapshot
    logic              dp_active, dp_write;
    logic              prev_capture;
    logic [1:0]        prev_htrans;
    logic              prev_hwrite;
    logic [W_ADDR-1:0] prev_haddr;
    logic [2:0]        prev_hsize;
    logic [2:0]        prev_hburst;
    logic [3:0]        prev_hprot;
    logic              prev_hmastlock;
    logic              prev_hready;
    logic [W_DATA-1:0] prev_hwdata;
    logic [7:0]        wait_cnt;

    // decoded bus
    logic              tr_idle, tr_busy, tr_nseq, tr_seq, addr_active;
    logic [W_ADDR-1:0] size_bytes, size_mask;
    logic              start_burst, fixed_init, wrap_init;
    logic [2:0]        beat_lsh;
    logic [3:0]        remain_init;
    logic [W_ADDR-1:0] mask_init, start_next, seq_next;

    // violations
    logic align_v, size_v, stable_v, seq_order_v, burst_v, wdata_v, resp_v, timeout_v;
    logic [7:0] viol;
    logic       any_v;
    logic [2:0] first_idx;
    logic       xfer_done;

    assign tr_idle     = (htrans == TR_IDLE);
    assign tr_busy     = (htrans == TR_BUSY);
    assign tr_nseq     = (htrans == TR_NSEQ);
    assign tr_seq      = (htrans == TR_SEQ);
    assign addr_active = htrans[1];

    assign size_bytes = A_ONE << hsize;
    assign size_mask  = size_bytes - A_ONE;

    // Wrap mask is beats*bytes-1; incrementing bursts use an all-ones mask so
    // the same next-address expression degenerates to a plain increment.
    assign start_burst = tr_nseq && (hburst != 3'b000);
    assign fixed_init  = (hburst[2:1] != 2'b00);
    assign wrap_init   = fixed_init && !hburst[0];
    assign beat_lsh    = {1'b0, hburst[2:1]} + 3'd1;
    assign mask_init   = wrap_init ? ((size_bytes << beat_lsh) - A_ONE) : '1;
    assign start_next  = (haddr & ~mask_init) | ((haddr + size_bytes) & mask_init);
    assign seq_next    = (haddr & ~b_mask) | ((haddr + size_bytes) & b_mask);

    // Beats remaining after the NSEQ beat of a fixed-length burst
    always_comb begin
        remain_init = 4'd0;
        case (hburst[2:1])
            2'b01:   remain_init = 4'd3;
            2'b10:   remain_init = 4'd7;
            2'b11:   remain_init = 4'd15;
            default: remain_init = 4'd0;
        endcase
    end

    assign align_v   = addr_active && ((haddr & size_mask) != '0);
    assign size_v    = addr_active && ((32'd8 << hsize) > 32'(W_DATA));
    assign wdata_v   = dp_active && dp_write && !prev_hready && (hwdata != prev_hwdata);
    assign timeout_v = dp_active && !hready && (wait_cnt == WAIT_LAST);
    assign xfer_done = dp_active && hready && !hresp;

    // A stalled address phase must hold every control field; only the
    // master's cancellation to IDLE during the error's second cycle is legal.
    always_comb begin
        stable_v = 1'b0;
        if (prev_capture) begin
            if ((htrans != prev_htrans) && !((r_state == R_ERR1) && tr_idle))
                stable_v = 1'b1;
            if ((hwrite != prev_hwrite) || (haddr != prev_haddr) || (hsize != prev_hsize) ||
                (hburst != prev_hburst) || (hprot != prev_hprot) ||
                (hmastlock != prev_hmastlock))
                stable_v = 1'b1;
        end
    end

    // Burst FSM next state plus SEQ_ORDER and BURST checks
    always_comb begin
        b_state_n   = b_state;
        b_remain_n  = b_remain;
        b_fixed_n   = b_fixed;
        b_exp_n     = b_exp;
        b_mask_n    = b_mask;
        b_last_n    = b_last;
        seq_order_v = 1'b0;
        burst_v     = 1'b0;
        if (b_state == B_IDLE) begin
            if (tr_seq || tr_busy)
                seq_order_v = 1'b1;
            if (tr_seq && b_last)
                burst_v = 1'b1;
            if (hready) begin
                b_last_n = 1'b0;
                if (start_burst) begin
                    b_state_n  = B_BURST;
                    b_remain_n = remain_init;
                    b_fixed_n  = fixed_init;
                    b_mask_n   = mask_init;
                    b_exp_n    = start_next;
                end
            end
        end else begin
            if (tr_seq && (haddr != b_exp))
                burst_v = 1'b1;
            if ((tr_idle || tr_nseq) && b_fixed && !hresp)
                burst_v = 1'b1;
            if (hready) begin
                b_last_n = 1'b0;
                if (tr_seq) begin
                    b_exp_n = seq_next;
                    if (b_fixed) begin
                        b_remain_n = b_remain - 4'd1;
                        if (b_remain == 4'd1) begin
                            b_state_n = B_IDLE;
                            b_last_n  = 1'b1;
                        end
                    end
                end else if (tr_idle) begin
                    b_state_n = B_IDLE;
                end else if (tr_nseq) begin
                    if (start_burst) begin
                        b_remain_n = remain_init;
                        b_fixed_n  = fixed_init;
                        b_mask_n   = mask_init;
                        b_exp_n    = start_next;
                    end else begin
                        b_state_n = B_IDLE;
                    end
                end
            end
        end
    end

    // Burst FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_state  <= B_IDLE;
            b_remain <= 4'd0;
            b_fixed  <= 1'b0;
            b_exp    <= '0;
            b_mask   <= '0;
            b_last   <= 1'b0;
        end else begin
            b_state  <= b_state_n;
            b_remain <= b_remain_n;
            b_fixed  <= b_fixed_n;
            b_exp    <= b_exp_n;
            b_mask   <= b_mask_n;
            b_last   <= b_last_n;
        end
    end

    // Response FSM next state plus the two-cycle error response check
    always_comb begin
        r_state_n = r_state;
        resp_v    = 1'b0;
        if (r_state == R_OK) begin
            if (hresp && hready)
                resp_v = 1'b1;
            if (dp_active && hresp && !hready)
                r_state_n = R_ERR1;
        end else begin
            if (!(hresp && hready))
                resp_v = 1'b1;
            r_state_n = R_OK;
        end
    end

    // Response FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= R_OK;
        else
            r_state <= r_state_n;
    end

    // Data-phase attributes follow the address phase once it is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_active <= 1'b0;
            dp_write  <= 1'b0;
        end else if (hready) begin
            dp_active <= addr_active;
            dp_write  <= hwrite;
        end
    end

    // Previous-cycle snapshot used by the stability and write-data checks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_capture   <= 1'b0;
            prev_htrans    <= 2'b00;
            prev_hwrite    <= 1'b0;
            prev_haddr     <= '0;
            prev_hsize     <= 3'd0;
            prev_hburst    <= 3'd0;
            prev_hprot     <= 4'd0;
            prev_hmastlock <= 1'b0;
            prev_hready    <= 1'b0;
            prev_hwdata    <= '0;
        end else begin
            prev_capture   <= addr_active && !hready && (r_state == R_OK);
            prev_htrans    <= htrans;
            prev_hwrite    <= hwrite;
            prev_haddr     <= haddr;
            prev_hsize     <= hsize;
            prev_hburst    <= hburst;
            prev_hprot     <= hprot;
            prev_hmastlock <= hmastlock;
            prev_hready    <= hready;
            prev_hwdata    <= hwdata;
        end
    end

    // Wait-state counter; saturating so the timeout fires once per stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= 8'd0;
        else if (hready)
            wait_cnt <= 8'd0;
        else if (dp_active && (wait_cnt != WAIT_MAX))
            wait_cnt <= wait_cnt + 8'd1;
    end

    assign viol  = {timeout_v, resp_v, wdata_v, burst_v, seq_order_v, stable_v, size_v, align_v};
    assign any_v = |viol;

    // Lowest-numbered violation firing this cycle
    always_comb begin
        first_idx = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (viol[i])
                first_idx = 3'(i);
    end

    assign err_valid = |err_flags;

    // Sticky flags and saturating counters; a violation coincident with clr survives it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flags  <= 8'h00;
            err_first  <= 3'd0;
            err_count  <= '0;
            xfer_count <= '0;
        end else if (clr) begin
            err_flags  <= viol;
            err_first  <= any_v ? first_idx : 3'd0;
            err_count  <= any_v ? CNT_ONE : '0;
            xfer_count <= '0;
        end else begin
            err_flags <= err_flags | viol;
            if (any_v && (err_flags == 8'h00))
                err_first <= first_idx;
            if (any_v && (err_count != '1))
                err_count <= err_count + CNT_ONE;
            if (xfer_done && (xfer_count != '1))
                xfer_count <= xfer_count + CNT_ONE;
        end
    end

endmodule
